// File: rtl/test_sig_chk.sv
// test_sig_chk -- AXI4-Stream phase-stream checker.
//
// Consumes the multi-lane phase stream of test_sig_gen. Locks onto the first
// accepted beat, predicts every following lane phase from the phase increment,
// counts accepted beats and mismatching lanes, and records the first failing beat.
//
// Ports:
//   s_axis_aclk     in   clock
//   s_axis_aresetn  in   asynchronous active-low reset
//   s_axis_tdata    in   LANES*LANE_W stream data, lane k = tdata[k*LANE_W +: LANE_W]
//   s_axis_tvalid   in   stream valid
//   s_axis_tready   out  stream ready (registered, throttled by stall_mask)
//   pinc            in   expected phase increment per sample (sampled while acquiring)
//   enable          in   1 = accept and check, 0 = tready low, state held
//   resync          in   pulse: drop lock, re-acquire on the next beat
//   clear           in   pulse: zero counters and error capture
//   stall_mask      in   tready throttle pattern, bit i gates cycle i mod 8
//   locked          out  tracking a locked stream
//   beat_cnt        out  beats accepted since lock (saturating)
//   err_cnt         out  mismatching lanes (saturating)
//   err_flag        out  sticky, set on the first mismatch
//   first_err_beat  out  beat_cnt value of the first failing beat
module test_sig_chk #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned LANE_W  = 32,
    parameter int unsigned PHASE_W = 20,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,
    input  logic [LANES*LANE_W-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [PHASE_W-1:0]      pinc,
    input  logic                    enable,
    input  logic                    resync,
    input  logic                    clear,
    input  logic [7:0]              stall_mask,
    output logic                    locked,
    output logic [CNT_W-1:0]        beat_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    err_flag,
    output logic [CNT_W-1:0]        first_err_beat
);

    localparam int unsigned MW = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         stall_ph_q, stall_ph_d;
    logic               tready_q, tready_d;
    logic [PHASE_W-1:0] pinc_q, pinc_d;
    logic [PHASE_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   first_q, first_d;
    logic               flag_q, flag_d;

    logic [PHASE_W-1:0] lane_p [LANES];
    logic               lane_unused;
    logic               accept;
    logic               in_acq;
    logic [PHASE_W-1:0] ref_base;
    logic [PHASE_W-1:0] ref_step;
    logic [PHASE_W-1:0] lane_exp;
    logic [MW-1:0]      mism_cnt;
    logic [CNT_W-1:0]   beat_base, err_base, first_base;
    logic               flag_base;
    logic [CNT_W:0]     err_sum;
    logic [CNT_W-1:0]   err_sat;
    logic [CNT_W-1:0]   beat_inc;
    logic [CNT_W-1:0]   beat_new;

    // Lane extraction; bits above PHASE_W in each lane slot are ignored.
    always_comb begin
        lane_unused = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_p[k]   = s_axis_tdata[k*LANE_W +: PHASE_W];
            lane_unused = lane_unused ^ (^s_axis_tdata[k*LANE_W+PHASE_W +: LANE_W-PHASE_W]);
        end
    end

    // Handshake follows the registered tready, so a beat already offered in the
    // cycle enable drops is still consumed and checked (AXI forbids discarding it).
    assign accept = s_axis_tvalid && tready_q;

    // A resync arriving together with a beat turns that beat into the acquire beat.
    assign in_acq = (state_q == ST_ACQ) || ((state_q == ST_TRACK) && resync);

    always_comb begin
        ref_base = in_acq ? lane_p[0] : exp_q;
        ref_step = in_acq ? pinc : pinc_q;
        mism_cnt = '0;
        lane_exp = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_exp = ref_base + ref_step * PHASE_W'(k);
            if (lane_p[k] != lane_exp) begin
                mism_cnt = mism_cnt + MW'(1);
            end
        end
    end

    // Clear acts first; a beat accepted in the same cycle then counts from zero.
    always_comb begin
        beat_base  = clear ? '0   : beat_q;
        err_base   = clear ? '0   : err_q;
        first_base = clear ? '0   : first_q;
        flag_base  = clear ? 1'b0 : flag_q;
        err_sum    = {1'b0, err_base} + (CNT_W+1)'(mism_cnt);
        err_sat    = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        beat_inc   = (beat_base == '1) ? beat_base : beat_base + CNT_W'(1);
        beat_new   = in_acq ? CNT_W'(1) : beat_inc;
    end

    always_comb begin
        state_d = state_q;
        pinc_d  = pinc_q;
        exp_d   = exp_q;
        beat_d  = beat_base;
        err_d   = err_base;
        first_d = first_base;
        flag_d  = flag_base;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ, ST_TRACK: begin
                if (accept) begin
                    state_d = ST_TRACK;
                    beat_d  = beat_new;
                    err_d   = err_sat;
                    if (in_acq) begin
                        pinc_d = pinc;
                    end
                    if ((mism_cnt != '0) && !flag_base) begin
                        flag_d  = 1'b1;
                        first_d = beat_new;
                    end
                    // After any mismatch, re-anchor on the last lane so a single
                    // glitch is not counted again on every later beat.
                    if (in_acq || (mism_cnt != '0)) begin
                        exp_d = lane_p[LANES-1] + ref_step;
                    end else begin
                        exp_d = exp_q + ref_step * PHASE_W'(LANES);
                    end
                end else if (resync) begin
                    state_d = ST_ACQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stall_ph_d = stall_ph_q + 3'd1;
        // tready for the coming cycle, indexed by that cycle's stall phase.
        tready_d   = enable && stall_mask[stall_ph_d] && (state_d != ST_IDLE);
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q    <= ST_IDLE;
            stall_ph_q <= '0;
            tready_q   <= 1'b0;
            pinc_q     <= '0;
            exp_q      <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            first_q    <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_ph_q <= stall_ph_d;
            tready_q   <= tready_d;
            pinc_q     <= pinc_d;
            exp_q      <= exp_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            first_q    <= first_d;
            flag_q     <= flag_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign locked         = (state_q == ST_TRACK);
    assign beat_cnt       = beat_q;
    assign err_cnt        = err_q;
    assign err_flag       = flag_q;
    assign first_err_beat = first_q;

endmodule
